carry_chain_sub: RTL and testbench

Multi-cycle unsigned subtractor. Computes a − b chunk by chunk and carries a registered borrow between chunks, so each cycle exercises a short carry chain. It is the inverse-direction counterpart of the wide carry-chain adder regression: the same chain is used in borrow mode, with registered chunk boundaries. It sits as a regression/pnr test block between a valid/ready producer and a valid/ready consumer.

---
 rtl/carry_chain_pkg.sv | 21 ++
 rtl/carry_chain_sub_slice.sv | 25 ++
 rtl/carry_chain_sub.sv | 162 ++++++++++++++++
 tb/tb_carry_chain_sub.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/carry_chain_pkg.sv
// carry_chain_pkg: shared types and helpers for the chunked carry-chain blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package carry_chain_pkg;

    // Controller states shared by the carry-chain regression blocks.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default number of bits processed per RUN cycle.
    localparam int DEFAULT_CHUNK = 4;

    // Number of RUN cycles needed to cover 'width' bits, 'chunk' bits at a time.
    function automatic int nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/carry_chain_sub_slice.sv
// carry_chain_sub_slice: CHUNK-bit subtract with borrow-in/borrow-out (i_a - i_b - i_bin).
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: i_a/i_b chunk operands, i_bin borrow-in, o_d chunk difference, o_bout borrow-out.
module carry_chain_sub_slice
    import carry_chain_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_bin,
    output logic [CHUNK-1:0] o_d,
    output logic             o_bout
);

    // One extra bit on top catches the borrow: the CHUNK+1-bit result is
    // negative (top bit set) exactly when a < b + bin.
    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_bin};
    assign o_d    = w_full[CHUNK-1:0];
    assign o_bout = w_full[CHUNK];

endmodule

// File: rtl/carry_chain_sub.sv
// carry_chain_sub: multi-cycle unsigned a - b, CHUNK bits per cycle, registered borrow between chunks.
// Latency: out_valid rises NCHUNK edges after the accept edge (IDLE -> NCHUNK x RUN -> DONE).
// Backpressure: in_ready low from accept until out_valid&&out_ready; results held stable while stalled.
// Ports: clk/resetn (async active-low); in_valid/in_ready with a, b; out_valid/out_ready with
//        diff = (a-b) mod 2^WIDTH, borrow_out = (a<b), msb = diff[WIDTH-1].
// Option: define CARRY_CHAIN_SUB_ZERO_EN to add output 'zero' (1 in DONE iff diff==0).
module carry_chain_sub
    import carry_chain_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             msb
`ifdef CARRY_CHAIN_SUB_ZERO_EN
    ,
    output logic             zero
`endif
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    // Operands are zero-padded to a whole number of chunks so the last,
    // partial chunk goes through the same slice. Padding with zeros makes
    // the slice's borrow-out equal to the borrow out of bit WIDTH-1.
    localparam int PW     = NCHUNK * CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic [KW-1:0]    r_k;

    logic [31:0]      w_sh;
    logic [PW-1:0]    w_a_pad;
    logic [PW-1:0]    w_b_pad;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_ins;
    logic [WIDTH-1:0] w_msk;
    logic [WIDTH-1:0] w_diff_nxt;

    // ---------------- controller ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_k == LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- chunk datapath ----------------
    assign w_sh      = 32'(r_k) * 32'(CHUNK);
    assign w_a_pad   = PW'(r_a);
    assign w_b_pad   = PW'(r_b);
    assign w_a_chunk = CHUNK'(w_a_pad >> w_sh);
    assign w_b_chunk = CHUNK'(w_b_pad >> w_sh);

    carry_chain_sub_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .i_a    (w_a_chunk),
        .i_b    (w_b_chunk),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // Place the chunk result at its bit position; bits of the padded last
    // chunk that fall above WIDTH-1 are dropped by the truncation.
    assign w_ins      = WIDTH'(PW'(w_d) << w_sh);
    assign w_msk      = WIDTH'(PW'({CHUNK{1'b1}}) << w_sh);
    assign w_diff_nxt = (r_diff & ~w_msk) | w_ins;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_k      <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_k      <= '0;
        end else if (r_state == RUN) begin
            r_diff   <= w_diff_nxt;
            r_borrow <= w_bout;
            r_k      <= (r_k == LAST) ? '0 : r_k + 1'b1;
        end
    end

    assign diff       = r_diff;
    assign borrow_out = r_borrow;
    assign msb        = r_diff[WIDTH-1];

`ifdef CARRY_CHAIN_SUB_ZERO_EN
    // Sticky "every chunk so far was zero"; only the in-range bits of a
    // chunk count, so the padded part of the last chunk cannot clear it.
    logic r_zero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_zero <= 1'b0;
        end else if (w_accept) begin
            r_zero <= 1'b1;
        end else if ((r_state == RUN) && (w_ins != '0)) begin
            r_zero <= 1'b0;
        end
    end

    assign zero = r_zero && (r_state == DONE);
`endif

endmodule

// File: tb/tb_carry_chain_sub.sv
// tb_carry_chain_sub: scoreboard bench for carry_chain_sub, four instances (CHUNK 4,1,3,10; WIDTH 10).
// Latency: n/a.
// Backpressure: out_ready driven randomly / held low to stall results.
module tb_carry_chain_sub;

    localparam int N = 4;
    localparam int CHK [N] = '{4, 1, 3, 10};
`ifdef CARRY_CHAIN_SUB_ZERO_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] d;
        logic       bo;
        logic       m;
        logic       z;
    } exp_t;

    logic       clk;
    logic       resetn;
    logic       in_valid   [N];
    logic       in_ready   [N];
    logic [9:0] a          [N];
    logic [9:0] b          [N];
    logic       out_valid  [N];
    logic       out_ready  [N];
    logic [9:0] diff       [N];
    logic       borrow_out [N];
    logic       msb        [N];
    logic       zero       [N];

    exp_t exp_q [N][$];
    int   checks;
    int   errors;
    int   cyc;

    for (genvar g = 0; g < N; g++) begin : g_dut
        carry_chain_sub #(
            .WIDTH (10),
            .CHUNK (CHK[g])
        ) u_dut (
            .clk        (clk),
            .resetn     (resetn),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .a          (a[g]),
            .b          (b[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .diff       (diff[g]),
            .borrow_out (borrow_out[g]),
            .msb        (msb[g])
`ifdef CARRY_CHAIN_SUB_ZERO_EN
            ,
            .zero       (zero[g])
`endif
        );
`ifndef CARRY_CHAIN_SUB_ZERO_EN
        assign zero[g] = 1'b0;
`endif
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: plain modular arithmetic on integers.
    function automatic exp_t model(input int av, input int bv);
        exp_t e;
        int   d;
        d    = (av - bv + 1024) % 1024;
        e.d  = 10'(d);
        e.bo = (av < bv);
        e.m  = (d >= 512);
        e.z  = ZEN && (d == 0);
        return e;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int   acc    [N];
        bit   acc_ok [N];
        bit   held   [N];
        exp_t prev   [N];
        exp_t cur;
        exp_t e;
        int   lat;
        int   nch;
        checks = 0;
        errors = 0;
        for (int g = 0; g < N; g++) begin
            acc[g] = 0; acc_ok[g] = 0; held[g] = 0; prev[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < N; g++) begin
                cur = {diff[g], borrow_out[g], msb[g], zero[g]};
                nch = (10 + CHK[g] - 1) / CHK[g];
                if (!resetn) begin
                    checks++;
                    if ({out_valid[g], in_ready[g], cur} !== {1'b0, 1'b1, 13'h0}) begin
                        errors++;
                        $display("FAIL reset_state inst%0d got ov=%b ir=%b d=%h bo=%b m=%b z=%b want ov=0 ir=1 all zero",
                                 g, out_valid[g], in_ready[g], cur.d, cur.bo, cur.m, cur.z);
                    end
                    exp_q[g].delete();
                    acc_ok[g] = 0;
                    held[g]   = 0;
                end else begin
                    if (!out_valid[g] && !acc_ok[g]) begin
                        checks++;
                        if (in_ready[g] !== 1'b1) begin
                            errors++;
                            $display("FAIL idle_ready inst%0d got in_ready=%b want 1", g, in_ready[g]);
                        end
                    end
                    if (in_valid[g] && in_ready[g]) begin
                        acc[g]    = cyc + 1;
                        acc_ok[g] = 1;
                    end
                    if (out_valid[g]) begin
                        checks++;
                        if (in_ready[g] !== 1'b0) begin
                            errors++;
                            $display("FAIL done_ready inst%0d got in_ready=%b want 0", g, in_ready[g]);
                        end
                        checks++;
                        if (held[g]) begin
                            if (cur !== prev[g]) begin
                                errors++;
                                $display("FAIL stall_stable inst%0d got %h want %h", g, cur, prev[g]);
                            end
                        end else begin
                            lat = cyc - acc[g] + 1;
                            if (!acc_ok[g] || lat != nch + 1) begin
                                errors++;
                                $display("FAIL latency inst%0d got %0d edges (accepted=%0d) want %0d",
                                         g, lat, acc_ok[g], nch + 1);
                            end
                        end
                        if (out_ready[g]) begin
                            checks++;
                            if (exp_q[g].size() == 0) begin
                                errors++;
                                $display("FAIL spurious_result inst%0d got d=%h with nothing expected", g, cur.d);
                            end else begin
                                e = exp_q[g].pop_front();
                                if (cur !== e) begin
                                    errors++;
                                    $display("FAIL result inst%0d got d=%h bo=%b m=%b z=%b want d=%h bo=%b m=%b z=%b",
                                             g, cur.d, cur.bo, cur.m, cur.z, e.d, e.bo, e.m, e.z);
                                end
                            end
                            held[g]   = 0;
                            acc_ok[g] = 0;
                        end else begin
                            held[g] = 1;
                            prev[g] = cur;
                        end
                    end else if (acc_ok[g] && (cyc - acc[g] > 100)) begin
                        checks++;
                        errors++;
                        $display("FAIL result_timeout inst%0d got no out_valid in 100 cycles want one", g);
                        acc_ok[g] = 0;
                        exp_q[g].delete();
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // All tasks are entered and left at posedge+1.
    task automatic issue(input int g, input logic [9:0] av, input logic [9:0] bv);
        bit ok;
        ok          = 0;
        in_valid[g] = 1'b1;
        a[g]        = av;
        b[g]        = bv;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (in_ready[g]) begin
                exp_q[g].push_back(model(int'(av), int'(bv)));
                ok = 1;
            end
            @(posedge clk); #1;
        end
        in_valid[g] = 1'b0;
        if (!ok) begin
            $display("FAIL issue_timeout inst%0d got in_ready stuck low want accept", g);
            $fatal(1, "stalled");
        end
    endtask

    task automatic wait_out(input int g);
        bit ok;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = out_valid[g];
            @(posedge clk); #1;
        end
        if (!ok) begin
            $display("FAIL wait_out inst%0d got no out_valid want one", g);
            $fatal(1, "stalled");
        end
    endtask

    task automatic wait_empty(input int g);
        bit ok;
        ok = 0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = (exp_q[g].size() == 0) && !out_valid[g];
            @(posedge clk); #1;
        end
        if (!ok) begin
            $display("FAIL drain inst%0d got %0d results pending want 0", g, exp_q[g].size());
            $fatal(1, "stalled");
        end
    endtask

    task automatic sweep(input int g, input int n);
        logic [9:0] av;
        logic [9:0] bv;
        bit         done;
        for (int i = 0; i < n; i++) begin
            av = 10'($urandom_range(0, 1023));
            bv = 10'($urandom_range(0, 1023));
            case ($urandom_range(0, 7))
                0:       bv = av;
                1:       av = 10'h000;
                2:       bv = 10'h3FF;
                3:       begin av = 10'h3FF; bv = 10'h000; end
                default: ;
            endcase
            issue(g, av, bv);
            done = 0;
            for (int t = 0; t < 200 && !done; t++) begin
                out_ready[g] = ($urandom_range(0, 2) != 0);
                // Stray requests while busy must be ignored.
                in_valid[g]  = ($urandom_range(0, 7) == 0);
                a[g]         = 10'($urandom_range(0, 1023));
                b[g]         = 10'($urandom_range(0, 1023));
                @(negedge clk);
                done = out_valid[g] && out_ready[g];
                @(posedge clk); #1;
            end
            in_valid[g]  = 1'b0;
            out_ready[g] = 1'b0;
            if (!done) begin
                $display("FAIL sweep_timeout inst%0d got no result handshake want one", g);
                $fatal(1, "stalled");
            end
        end
    endtask

    initial begin
        resetn = 1'b1;
        for (int g = 0; g < N; g++) begin
            in_valid[g] = 1'b0; out_ready[g] = 1'b0; a[g] = '0; b[g] = '0;
        end
        #2 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases on the CHUNK=4 instance.
        out_ready[0] = 1'b1;
        issue(0, 10'h000, 10'h001);
        wait_empty(0);
        issue(0, 10'h200, 10'h001);
        wait_empty(0);
        issue(0, 10'h155, 10'h155);
        wait_empty(0);

        // Stall the result for 7 cycles with a stray request in the middle.
        out_ready[0] = 1'b0;
        issue(0, 10'h0F0, 10'h30F);
        wait_out(0);
        in_valid[0] = 1'b1; a[0] = 10'h123; b[0] = 10'h045;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        out_ready[0] = 1'b1;
        wait_empty(0);

        // Release and new request in the same DONE cycle.
        out_ready[0] = 1'b0;
        issue(0, 10'h2AA, 10'h0FF);
        wait_out(0);
        out_ready[0] = 1'b1;
        issue(0, 10'h001, 10'h3FE);
        wait_empty(0);

        // Reset during the second RUN cycle; the pending result is dropped.
        issue(0, 10'h3FF, 10'h000);
        @(posedge clk); #3;
        resetn = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        out_ready[0] = 1'b0;

        fork
            sweep(0, 1000);
            sweep(1, 1000);
            sweep(2, 1000);
            sweep(3, 1000);
        join
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
